// File: rtl/rng_share_ctrl_pkg.sv
// Shared types and constants for the shared 4-bit random source controller.
// The LFSR step function lives here so the generator and any model share one definition.
package rng_pkg;

    typedef enum logic {
        FILL = 1'b0,
        IDLE = 1'b1
    } rng_state_e;

    localparam int             RNG_W        = 4;
    localparam logic [RNG_W-1:0] LFSR_TAPS  = 4'b1100;
    localparam logic [RNG_W-1:0] DEFAULT_SEED = 4'b0001;
    localparam int             FILL_LEN     = 4;

    // Polynomial x^4+x^3+1: shift left, feed back the XOR of the tapped bits.
    function automatic logic [RNG_W-1:0] lfsr_step(input logic [RNG_W-1:0] s);
        return {s[RNG_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rng_share_ctrl_lfsr4.sv
// Free-running 4-bit maximal-length LFSR with a synchronous parallel load.
// Zero-seed protection is the caller's job; this block loads whatever it is given.
module lfsr4
    import rng_pkg::*;
#(
    parameter logic [RNG_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [RNG_W-1:0] load_val,
    output logic [RNG_W-1:0] state
);

    logic [RNG_W-1:0] state_d;
    logic [RNG_W-1:0] state_q;

    always_comb begin
        state_d = lfsr_step(state_q);
        if (load) begin
            state_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rng_share_ctrl.sv
// Round-robin distributor of fresh LFSR values; after each delivery a refill
// window lets every bit of the LFSR shift out before the next value is handed out.
module rng_share_ctrl
    import rng_pkg::*;
#(
    parameter int               N_REQ = 4,
    parameter logic [RNG_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [RNG_W-1:0] seed_value,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             rand_valid,
    output logic [RNG_W-1:0] rand_out,
    output logic             busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(FILL_LEN);

    rng_state_e       state_d, state_q;
    logic [CNT_W-1:0] fill_cnt_d, fill_cnt_q;
    logic [IDX_W-1:0] last_d, last_q;
    logic [N_REQ-1:0] grant_d, grant_q;
    logic [RNG_W-1:0] rand_out_d, rand_out_q;
    logic [RNG_W-1:0] lfsr_val;
    logic [RNG_W-1:0] lfsr_load_val;
    logic [IDX_W-1:0] winner;

    // Search begins one past the last winner so every requester gets a turn.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && r[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign lfsr_load_val = (seed_value == '0) ? SEED : seed_value;

    lfsr4 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (lfsr_load_val),
        .state    (lfsr_val)
    );

    assign winner = rr_pick(req, last_q);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        last_d     = last_q;
        grant_d    = '0;
        rand_out_d = rand_out_q;

        if (seed_load) begin
            state_d    = FILL;
            fill_cnt_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_cnt_q == CNT_W'(FILL_LEN - 1)) begin
                        state_d    = IDLE;
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (|req) begin
                        grant_d    = N_REQ'(1) << winner;
                        rand_out_d = lfsr_val;
                        last_d     = winner;
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            grant_q    <= '0;
            rand_out_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            rand_out_q <= rand_out_d;
        end
    end

    assign grant      = grant_q;
    assign rand_valid = |grant_q;
    assign rand_out   = rand_out_q;
    assign busy       = (state_q == FILL);

endmodule
